// File: rtl/axis_window_expander_if.sv
// AXI4-Stream bundle for the window expander: master drives data/valid/last,
// slave returns ready. The slave side carries no tlast.
interface axis_window_expander_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_window_expander.sv
// Replays one accepted window word as cfg+1 output beats; the low flag field
// is forwarded on the first beat only and cleared on every later beat.
module axis_window_expander #(
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int FLAG_WIDTH       = 66,
  parameter int CNTR_WIDTH       = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [CNTR_WIDTH-1:0]            cfg,
  axis_window_expander_if.slave            s_axis,
  axis_window_expander_if.master           m_axis
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [AXIS_TDATA_WIDTH-1:0] FLAG_CLEAR =
    {AXIS_TDATA_WIDTH{1'b1}} << FLAG_WIDTH;
  localparam logic [CNTR_WIDTH-1:0] CNTR_ZERO = {CNTR_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0] word_q, word_d;
  logic [CNTR_WIDTH-1:0]       len_q, len_d;
  logic [CNTR_WIDTH-1:0]       cntr_q, cntr_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                        m_tvalid_q, m_tvalid_d;
  logic                        m_tlast_q, m_tlast_d;

  logic s_tready_s;
  logic accept_s;
  logic m_hs_s;
  logic load_s;

  // Ready is combinational from downstream ready so windows can run back-to-back.
  assign s_tready_s = ~areset & ((state_q == ST_IDLE) |
                                 ((state_q == ST_EMIT) & (cntr_q == len_q) & m_axis.tready));
  assign accept_s   = s_axis.tvalid & s_tready_s;
  assign m_hs_s     = m_tvalid_q & m_axis.tready;

  assign s_axis.tready = s_tready_s;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    cntr_d  = cntr_q;
    load_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_EMIT: begin
        if (m_hs_s) begin
          if (cntr_q != len_q) begin
            cntr_d = cntr_q + CNTR_ONE;
          end else if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      word_d  = s_axis.tdata;
      len_d   = cfg;
      cntr_d  = CNTR_ZERO;
      state_d = ST_EMIT;
    end else begin
      word_d  = word_d;
    end

    // Outputs are precomputed from the next state so they leave the flops directly.
    m_tvalid_d = (state_d == ST_EMIT);
    m_tlast_d  = (state_d == ST_EMIT) && (cntr_d == len_d);
    if (state_d == ST_EMIT) begin
      if (cntr_d == CNTR_ZERO) begin
        m_tdata_d = word_d;
      end else begin
        m_tdata_d = word_d & FLAG_CLEAR;
      end
    end else begin
      m_tdata_d = m_tdata_q;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      word_q     <= {AXIS_TDATA_WIDTH{1'b0}};
      len_q      <= CNTR_ZERO;
      cntr_q     <= CNTR_ZERO;
      m_tdata_q  <= {AXIS_TDATA_WIDTH{1'b0}};
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      cntr_q     <= cntr_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

endmodule

// File: tb/tb_axis_window_expander.sv
// Bench for axis_window_expander: per-cycle checks against a queue of expected
// beats built from each accepted word and its window length.
module tb_axis_window_expander;
  localparam int W = 128;
  localparam int F = 66;
  localparam int C = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic [C-1:0] len;
  } word_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [C-1:0] cfg;

  axis_window_expander_if #(.DATA_WIDTH(W)) s_if ();
  axis_window_expander_if #(.DATA_WIDTH(W)) m_if ();

  axis_window_expander #(
    .AXIS_TDATA_WIDTH(W),
    .FLAG_WIDTH(F),
    .CNTR_WIDTH(C)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .cfg    (cfg),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  always #5 aclk = ~aclk;

  beat_t        exp_q[$];
  word_t        src_q[$];
  int           tests = 0;
  int           fails = 0;
  bit           rand_ready = 1'b0;
  logic [C-1:0] idle_cfg = 8'd0;
  int           n_cyc;
  logic [W-1:0] aa_word;

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_word(input logic [W-1:0] d, input logic [C-1:0] l);
    word_t w;
    w.data = d;
    w.len  = l;
    src_q.push_back(w);
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step();
    logic  exp_ready;
    logic  m_hs;
    logic  s_hs;
    word_t w;
    beat_t b;
    @(negedge aclk);
    chk_b("m_tvalid", m_if.tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk_w("m_tdata", m_if.tdata, exp_q[0].data);
      chk_b("m_tlast", m_if.tlast, exp_q[0].last);
    end
    m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (src_q.size() > 0) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = src_q[0].data;
      cfg         = src_q[0].len;
    end else begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = rand_word();
      cfg         = idle_cfg;
    end
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_if.tready);
    #1;
    chk_b("s_tready", s_if.tready, exp_ready);
    m_hs = (exp_q.size() > 0) && m_if.tready;
    s_hs = s_if.tvalid && exp_ready;
    @(posedge aclk);
    if (m_hs) void'(exp_q.pop_front());
    if (s_hs) begin
      w = src_q.pop_front();
      for (int k = 0; k <= int'(w.len); k++) begin
        b.data = (k == 0) ? w.data : ((w.data >> F) << F);
        b.last = (k == int'(w.len));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drain(input int limit, output int n);
    n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk_b("drain_done", (exp_q.size() == 0) && (src_q.size() == 0), 1'b1);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    cfg         = 8'd0;
    aa_word     = {32{4'hA}};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk_b("rst_tvalid", m_if.tvalid, 1'b0);
    chk_b("rst_tlast", m_if.tlast, 1'b0);
    chk_w("rst_tdata", m_if.tdata, {W{1'b0}});
    chk_b("rst_s_tready", s_if.tready, 1'b0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk_b("rel_s_tready", s_if.tready, 1'b1);

    // cfg=3, 0xAAAA... word: 4 beats
    push_word(aa_word, 8'd3);
    drain(50, n_cyc);
    chk_i("t1_cycles", n_cyc, 5);

    // cfg=0, 10 words streamed at full rate
    for (int i = 0; i < 10; i++) push_word(rand_word(), 8'd0);
    drain(100, n_cyc);
    chk_i("t2_cycles", n_cyc, 11);

    // cfg=2, two windows back-to-back
    push_word(rand_word(), 8'd2);
    push_word(rand_word(), 8'd2);
    drain(100, n_cyc);
    chk_i("t3_cycles", n_cyc, 7);

    // cfg=4 with random backpressure; cfg pin moved to 1 while emitting
    rand_ready = 1'b1;
    idle_cfg   = 8'd1;
    push_word(rand_word(), 8'd4);
    drain(500, n_cyc);
    push_word(rand_word(), 8'd4);
    push_word(rand_word(), 8'd1);
    push_word(rand_word(), 8'd3);
    drain(500, n_cyc);
    rand_ready = 1'b0;
    idle_cfg   = 8'd0;

    // cfg=255: 256 beats, no counter wrap
    push_word(rand_word(), 8'd255);
    drain(1000, n_cyc);
    chk_i("t5_cycles", n_cyc, 257);

    // Reset pulsed during beat 2 of a cfg=5 window
    push_word(rand_word(), 8'd5);
    repeat (3) step();
    #2;
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    chk_b("mid_rst_tvalid", m_if.tvalid, 1'b0);
    chk_b("mid_rst_tlast", m_if.tlast, 1'b0);
    chk_w("mid_rst_tdata", m_if.tdata, {W{1'b0}});
    chk_b("mid_rst_s_tready", s_if.tready, 1'b0);
    exp_q.delete();
    src_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk_b("mid_rel_s_tready", s_if.tready, 1'b1);
    push_word(rand_word(), 8'd1);
    drain(50, n_cyc);
    chk_i("t6_cycles", n_cyc, 3);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
